// File: rtl/sram_arb_2p.sv
// sram_arb_2p: two-requester arbiter/sequencer for one single-port SRAM macro.
//
// After reset the whole array is swept with INIT_VAL. Then at most one
// request per cycle is granted and driven straight onto the SRAM pins.
// Read data comes back on the requesting port two cycles after its handshake.
//
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration between the
// two ports. Without it, port 0 has fixed priority.
//
// Ports:
//   clk, rst       clock (also the SRAM clock) and async active-high reset
//   req_valid[1:0] per-port request valid
//   req_ready[1:0] per-port grant
//   req_we[1:0]    1 = write, 0 = read
//   req_addr       port i at [i*ADDR_W +: ADDR_W]
//   req_wdata      port i at [i*DATA_W +: DATA_W]
//   resp_valid     one-cycle read-response strobe per port
//   resp_rdata     per-port read data, held between strobes
//   init_done      high once the clear sweep has finished
//   sram_a/csb/web/oeb/i  SRAM address, chip select, write enable,
//                  output enable (tied low) and write data
//   sram_o         SRAM registered read data
//
// Handshake: a transfer on port i happens in a cycle where req_valid[i] and
// req_ready[i] are both high. req_ready depends combinationally on
// req_valid. A requester keeps valid, we, addr and wdata stable until it sees
// its handshake.
module sram_arb_2p #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_we,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            resp_valid,
    output logic [2*DATA_W-1:0]   resp_rdata,
    output logic                  init_done,
    output logic [ADDR_W-1:0]     sram_a,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic                  sram_oeb,
    output logic [DATA_W-1:0]     sram_i,
    input  logic [DATA_W-1:0]     sram_o
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ic;        // init sweep address
    logic [1:0]        gnt;       // one-hot grant, only ever on a valid port
    logic              hs;        // a handshake happens this cycle
    logic              gp;        // granted port id
    logic              g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic              s1_valid;  // read issued last cycle, data on sram_o now
    logic              s1_port;

`ifdef SRAM_ARB_RR_EN
    logic              ptr;       // port that wins the next contest
`endif

    // Grant selection. Only active in RUN; the grant always lands on a port
    // whose valid is set, so gnt is also the handshake vector.
    always_comb begin
        gnt = 2'b00;
        if (state == ST_RUN) begin
`ifdef SRAM_ARB_RR_EN
            if (req_valid == 2'b11)
                gnt = ptr ? 2'b10 : 2'b01;
            else
                gnt = req_valid;
`else
            if (req_valid[0])
                gnt = 2'b01;
            else if (req_valid[1])
                gnt = 2'b10;
`endif
        end
    end

    assign req_ready = gnt;
    assign hs        = |gnt;
    assign gp        = gnt[1];
    assign g_we      = gp ? req_we[1] : req_we[0];
    assign g_addr    = gp ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    assign g_wdata   = gp ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

    assign init_done = (state == ST_RUN);
    assign sram_oeb  = 1'b0;

    // SRAM pins. rst is included because the state register is already INIT
    // while reset is held, and the sweep must not write during that time.
    always_comb begin
        sram_csb = 1'b1;
        sram_web = 1'b1;
        sram_a   = '0;
        sram_i   = '0;
        if (rst) begin
            sram_csb = 1'b1;
        end else if (state == ST_INIT) begin
            sram_csb = 1'b0;
            sram_web = 1'b0;
            sram_a   = ic;
            sram_i   = INIT_VAL;
        end else if (hs) begin
            sram_csb = 1'b0;
            sram_web = ~g_we;
            sram_a   = g_addr;
            sram_i   = g_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_INIT;
            ic         <= '0;
            s1_valid   <= 1'b0;
            s1_port    <= 1'b0;
            resp_valid <= 2'b00;
            resp_rdata <= '0;
`ifdef SRAM_ARB_RR_EN
            ptr        <= 1'b0;
`endif
        end else begin
            if (state == ST_INIT) begin
                ic <= ic + 1'b1;
                if (ic == '1)
                    state <= ST_RUN;
            end

            // Stage 1: remember which port issued a read this cycle.
            s1_valid <= hs & ~g_we;
            s1_port  <= gp;

            // Stage 2: the macro's registered data is on sram_o now.
            resp_valid <= 2'b00;
            if (s1_valid) begin
                resp_valid[s1_port] <= 1'b1;
                if (s1_port)
                    resp_rdata[2*DATA_W-1:DATA_W] <= sram_o;
                else
                    resp_rdata[DATA_W-1:0] <= sram_o;
            end

`ifdef SRAM_ARB_RR_EN
            if (hs)
                ptr <= ~gp;
`endif
        end
    end

endmodule
